hs_pipe_fifo: RTL and testbench

HS_PIPE_FIFO -- requirements
Module: hs_pipe_fifo

---
 rtl/hs_pkg.sv | 23 ++
 rtl/hs_fifo_mem.sv | 34 +++
 rtl/hs_pipe_fifo.sv | 107 ++++++++++
 tb/tb_hs_pipe_fifo.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// ============================================================================
// hs_pkg
// Shared defaults and the pointer/count width helper for the hs_pipe_fifo slice.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hs_pkg;

  localparam int HS_DEFAULT_WIDTH = 32;
  localparam int HS_DEFAULT_DEPTH = 4;

  // Bits needed to address 'depth' entries; count needs one more bit.
  function automatic int hs_ptr_width(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hs_fifo_mem.sv
// ============================================================================
// hs_fifo_mem
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hs_fifo_mem
  import hs_pkg::*;
#(
  parameter int WIDTH = HS_DEFAULT_WIDTH,
  parameter int DEPTH = HS_DEFAULT_DEPTH
) (
  input  logic                            clk,
  input  logic                            we_i,
  input  logic [hs_ptr_width(DEPTH)-1:0]  waddr_i,
  input  logic [WIDTH-1:0]                wdata_i,
  input  logic [hs_ptr_width(DEPTH)-1:0]  raddr_i,
  output logic [WIDTH-1:0]                rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/hs_pipe_fifo.sv
// ============================================================================
// hs_pipe_fifo
// Valid/ready FIFO with registered in_ready and one-cycle latency (no bypass).
// Optional synchronous flush port enabled by macro HS_PIPE_FIFO_FLUSH_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hs_pipe_fifo
  import hs_pkg::*;
#(
  parameter int WIDTH     = HS_DEFAULT_WIDTH,
  parameter int DEPTH     = HS_DEFAULT_DEPTH,
  parameter int AFULL_LVL = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
`ifdef HS_PIPE_FIFO_FLUSH_EN
  input  logic                          flush,
`endif
  output logic [hs_ptr_width(DEPTH):0]  count,
  output logic                          almost_full
);

  localparam int PW = hs_ptr_width(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          in_ready_q, in_ready_d;
  logic          push;
  logic          pop;
  logic          mem_we;

  assign in_ready    = in_ready_q;
  assign out_valid   = (count_q != '0);
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AFULL_LVL));

  always_comb begin
    push       = in_valid & in_ready_q;
    pop        = out_valid & out_ready;
    mem_we     = push;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end

`ifdef HS_PIPE_FIFO_FLUSH_EN
    // Flush wins over any same-cycle handshake, including the write.
    if (flush) begin
      mem_we   = 1'b0;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
`endif

    // in_ready is registered from the next occupancy, so a pop on a full
    // FIFO only reopens the input one cycle later.
    in_ready_d = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_ready_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
    end
  end

  hs_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_hs_pipe_fifo.sv
// ============================================================================
// tb_hs_pipe_fifo
// Self-checking bench for hs_pipe_fifo against a queue-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hs_pipe_fifo;

  localparam int WIDTH     = 32;
  localparam int DEPTH     = 4;
  localparam int AFULL_LVL = 3;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    count;
  logic             almost_full;
`ifdef HS_PIPE_FIFO_FLUSH_EN
  logic             flush = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] mq[$];
  bit               m_rdy = 1'b0;

  always #5 clk = ~clk;

  hs_pipe_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
`ifdef HS_PIPE_FIFO_FLUSH_EN
    .flush       (flush),
`endif
    .count       (count),
    .almost_full (almost_full)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("count", 64'(count), 64'(mq.size()));
    check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("in_ready", 64'(in_ready), 64'(m_rdy));
    check("almost_full", 64'(almost_full), 64'(mq.size() >= AFULL_LVL));
    if (mq.size() != 0) check("out_data", 64'(out_data), 64'(mq[0]));
  endtask

  // One clock: check at the falling edge, drive, then advance the model at the rising edge.
  task automatic cycle(input bit rn, input bit v, input logic [WIDTH-1:0] d, input bit r, input bit fl);
    bit do_push, do_pop;
    @(negedge clk);
    check_outputs();
    rst_n     = rn;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
`ifdef HS_PIPE_FIFO_FLUSH_EN
    flush     = fl;
`endif
    if (!rn) begin
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      m_rdy = 1'b0;
    end else if (fl) begin
`ifdef HS_PIPE_FIFO_FLUSH_EN
      mq.delete();
      m_rdy = 1'b1;
`endif
    end else begin
      do_push = v && m_rdy;
      do_pop  = (mq.size() != 0) && r;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(d);
      m_rdy = (mq.size() != DEPTH);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;

    // Reset and first push of 0xA5
    cycle(0, 0, '0, 0, 0);
    cycle(0, 0, '0, 0, 0);
    cycle(1, 1, 32'hA5, 0, 0);
    cycle(1, 1, 32'hA5, 0, 0);
    cycle(1, 0, '0, 0, 0);
    check("a5_visible", 64'(out_data), 64'hA5);
    cycle(1, 0, '0, 1, 0);
    cycle(1, 0, '0, 1, 0);

    // Fill to full with 1..5, then pop-on-full with 6 offered
    for (int i = 1; i <= 5; i++) cycle(1, 1, WIDTH'(i), 0, 0);
    cycle(1, 1, 32'h6, 1, 0);
    cycle(1, 1, 32'h6, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, '0, 1, 0);

    // Streaming 0..19 at full rate
    for (int i = 0; i < 20; i++) cycle(1, 1, WIDTH'(i), 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, '0, 1, 0);

    // Reset mid-stream with three entries held
    for (int i = 0; i < 3; i++) cycle(1, 1, WIDTH'(32'h30 + i), 0, 0);
    cycle(0, 1, 32'h99, 1, 0);
    cycle(1, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, '0, 1, 0);

`ifdef HS_PIPE_FIFO_FLUSH_EN
    // Flush with a simultaneous push of 0x7
    cycle(1, 1, 32'h51, 0, 0);
    cycle(1, 1, 32'h52, 0, 0);
    cycle(1, 1, 32'h7, 0, 1);
    cycle(1, 0, '0, 1, 0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) cycle(1, 0, '0, 1, 0);
`endif

    // Randomized traffic with varying fill pressure and rare resets/flushes
    for (int i = 0; i < 600; i++) begin
      bit v, r, rn, fl;
      v  = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r  = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      rn = ($urandom_range(0, 99) != 0);
      fl = 1'b0;
`ifdef HS_PIPE_FIFO_FLUSH_EN
      fl = ($urandom_range(0, 49) == 0);
`endif
      cycle(rn, v, WIDTH'($urandom), r, fl);
    end
    cycle(1, 0, '0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
